// File: rtl/bus_grant_scheduler.sv
// Purpose : grant controller for the shared SRAM port (master 0 = IFU, master 1 = LSU);
//           drives the one-hot select of the AXI4-Lite mux beside it.
// Latency : grant registered, 1 cycle after req/prerequest; back-to-back handover on done.
// Backpressure: the owner holds the grant until its done; losers wait, bounded by starvation counters.
// Ports   : clk_i, rst_i (sync, active-high); prerequest_i/req_i/done_i per master;
//           grant_o one-hot owner, grant_id_o binary owner (0 when idle), busy_o = not idle.
// Option  : define BUS_SCHED_RR_EN for round-robin base policy; default is fixed priority,
//           highest index wins. Starvation forcing (lowest index first) is active in both builds.
module bus_grant_scheduler #(
    parameter int NMST     = 2,
    parameter int MAX_WAIT = 15,
    parameter int RSV_WIN  = 2,
    localparam int IDW     = (NMST > 1) ? $clog2(NMST) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NMST-1:0] prerequest_i,
    input  logic [NMST-1:0] req_i,
    input  logic [NMST-1:0] done_i,
    output logic [NMST-1:0] grant_o,
    output logic [IDW-1:0]  grant_id_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RSV,
        ST_OWN
    } state_t;

    localparam logic [7:0] MAX_W    = 8'(MAX_WAIT);
    localparam logic [7:0] RSV_LAST = 8'(RSV_WIN - 1);

    state_t                 state_q, state_d;
    logic [NMST-1:0]        grant_q, grant_d;
    logic [IDW-1:0]         gid_q, gid_d;
    logic [7:0]             rsv_q, rsv_d;
    logic [NMST-1:0][7:0]   wait_q, wait_d;
    logic [NMST-1:0]        sat_vec;
    logic [NMST-1:0]        cand;
    logic                   win_vld;
    logic [IDW-1:0]         win_idx;
    logic                   new_grant;
`ifdef BUS_SCHED_RR_EN
    logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
`endif

    // Starved candidates win first (lowest index); otherwise the base policy decides.
    function automatic logic [IDW:0] arbitrate(input logic [NMST-1:0] c,
                                               input logic [NMST-1:0] sat);
        logic           found;
        logic [IDW-1:0] idx;
`ifdef BUS_SCHED_RR_EN
        int             j;
`endif
        found = 1'b0;
        idx   = '0;
        // Descending scan so the lowest starved index is the last write.
        for (int i = NMST - 1; i >= 0; i--) begin
            if (c[i] && sat[i]) begin
                found = 1'b1;
                idx   = i[IDW-1:0];
            end
        end
        if (!found) begin
`ifdef BUS_SCHED_RR_EN
            // Scan backwards from the far end so the first hit at/after rr_ptr wins.
            for (int k = NMST - 1; k >= 0; k--) begin
                j = (int'(rr_ptr_q) + k) % NMST;
                if (c[j]) begin
                    found = 1'b1;
                    idx   = j[IDW-1:0];
                end
            end
`else
            // Ascending scan: the highest requesting index is the last write.
            for (int i = 0; i < NMST; i++) begin
                if (c[i]) begin
                    found = 1'b1;
                    idx   = i[IDW-1:0];
                end
            end
`endif
        end
        return {found, idx};
    endfunction

    always_comb begin
        for (int i = 0; i < NMST; i++) begin
            sat_vec[i] = (wait_q[i] == MAX_W);
            if (grant_q[i] || !(req_i[i] || prerequest_i[i])) begin
                wait_d[i] = 8'd0;
            end else if (wait_q[i] != MAX_W) begin
                wait_d[i] = wait_q[i] + 8'd1;
            end else begin
                wait_d[i] = wait_q[i];
            end
        end
    end

    // IDLE arbitrates live requests before hints; OWN re-arbitrates with the owner masked.
    always_comb begin
        cand = '0;
        if (state_q == ST_OWN) begin
            cand = req_i & ~grant_q;
        end else if (|req_i) begin
            cand = req_i;
        end else begin
            cand = prerequest_i;
        end
        {win_vld, win_idx} = arbitrate(cand, sat_vec);
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gid_d     = gid_q;
        rsv_d     = rsv_q;
        new_grant = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    new_grant = 1'b1;
                    state_d   = (|req_i) ? ST_OWN : ST_RSV;
                    rsv_d     = 8'd0;
                end
            end
            ST_RSV: begin
                if (req_i[gid_q]) begin
                    state_d = ST_OWN;
                end else if (rsv_q == RSV_LAST) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    gid_d   = '0;
                end else begin
                    rsv_d = rsv_q + 8'd1;
                end
            end
            ST_OWN: begin
                if (done_i[gid_q]) begin
                    if (win_vld) begin
                        new_grant = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        gid_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                gid_d   = '0;
            end
        endcase
        if (new_grant) begin
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            gid_d            = win_idx;
        end
    end

`ifdef BUS_SCHED_RR_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (new_grant) begin
            if (int'(win_idx) == NMST - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = win_idx + 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            gid_q    <= '0;
            rsv_q    <= 8'd0;
            wait_q   <= '0;
`ifdef BUS_SCHED_RR_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gid_q    <= gid_d;
            rsv_q    <= rsv_d;
            wait_q   <= wait_d;
`ifdef BUS_SCHED_RR_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign grant_o    = grant_q;
    assign grant_id_o = gid_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus_grant_scheduler.sv
// Purpose : directed checks of bus_grant_scheduler (default fixed-priority build, MAX_WAIT=3).
// Latency : one stimulus cycle per step, outputs checked 1 time unit after the next rising edge.
// Backpressure: n/a; expected grants are pushed per step and popped after the edge.
module tb_bus_grant_scheduler;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [1:0] prerequest_i = 2'b00;
    logic [1:0] req_i = 2'b00;
    logic [1:0] done_i = 2'b00;
    logic [1:0] grant_o;
    logic       grant_id_o;
    logic       busy_o;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct packed {
        logic [1:0] grant;
        logic       id;
        logic       busy;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    always #5 clk_i = ~clk_i;

    bus_grant_scheduler #(
        .NMST     (2),
        .MAX_WAIT (3),
        .RSV_WIN  (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .prerequest_i (prerequest_i),
        .req_i        (req_i),
        .done_i       (done_i),
        .grant_o      (grant_o),
        .grant_id_o   (grant_id_o),
        .busy_o       (busy_o)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, record the grant expected after the edge, then compare.
    // Owner index and busy follow from the expected grant (idle <=> no grant).
    task automatic cyc(input string tag, input logic r, input logic [1:0] rq,
                       input logic [1:0] pr, input logic [1:0] dn, input logic [1:0] eg);
        exp_t  e;
        string t;
        e.grant = eg;
        e.id    = eg[1];
        e.busy  = |eg;
        rst_i        = r;
        req_i        = rq;
        prerequest_i = pr;
        done_i       = dn;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk_i);
        #1;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".grant"}, {6'd0, grant_o}, {6'd0, e.grant});
        check({t, ".id"},    {7'd0, grant_id_o}, {7'd0, e.id});
        check({t, ".busy"},  {7'd0, busy_o}, {7'd0, e.busy});
    endtask

    initial begin
        // reset state
        cyc("rst0", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        cyc("rst1", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);

        // single IFU transaction, held 4 cycles; foreign and idle done ignored
        cyc("t1.req",      1'b0, 2'b01, 2'b00, 2'b00, 2'b01);
        cyc("t1.hold1",    1'b0, 2'b01, 2'b00, 2'b00, 2'b01);
        cyc("t1.foreign",  1'b0, 2'b01, 2'b00, 2'b10, 2'b01);
        cyc("t1.hold3",    1'b0, 2'b01, 2'b00, 2'b00, 2'b01);
        cyc("t1.done",     1'b0, 2'b00, 2'b00, 2'b01, 2'b00);
        cyc("t1.idledone", 1'b0, 2'b00, 2'b00, 2'b11, 2'b00);

        // fixed priority from IDLE: LSU wins every time
        for (int n = 0; n < 3; n++) begin
            cyc($sformatf("t2.req%0d", n),  1'b0, 2'b11, 2'b00, 2'b00, 2'b10);
            cyc($sformatf("t2.done%0d", n), 1'b0, 2'b00, 2'b00, 2'b10, 2'b00);
        end

        // reservation converted to ownership
        cyc("t3.pre",   1'b0, 2'b00, 2'b10, 2'b00, 2'b10);
        cyc("t3.req",   1'b0, 2'b10, 2'b00, 2'b00, 2'b10);
        cyc("t3.own",   1'b0, 2'b00, 2'b00, 2'b00, 2'b10);
        cyc("t3.done",  1'b0, 2'b00, 2'b00, 2'b10, 2'b00);
        // reservation expiring after two cycles; other master's req ignored meanwhile
        cyc("t3.pre2",  1'b0, 2'b00, 2'b10, 2'b00, 2'b10);
        cyc("t3.wait1", 1'b0, 2'b01, 2'b00, 2'b00, 2'b10);
        cyc("t3.wait2", 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);
        cyc("t3.after", 1'b0, 2'b01, 2'b00, 2'b00, 2'b01);
        cyc("t3.adone", 1'b0, 2'b00, 2'b00, 2'b01, 2'b00);

        // back-to-back handover without a bubble, both directions
        cyc("t5.req",   1'b0, 2'b01, 2'b00, 2'b00, 2'b01);
        cyc("t5.swap",  1'b0, 2'b10, 2'b00, 2'b01, 2'b10);
        cyc("t5.hold",  1'b0, 2'b11, 2'b00, 2'b00, 2'b10);
        cyc("t5.swap2", 1'b0, 2'b11, 2'b00, 2'b10, 2'b01);
        cyc("t5.done",  1'b0, 2'b00, 2'b00, 2'b01, 2'b00);

        // starvation: IFU hint waits through a long LSU transfer, then is forced over LSU
        cyc("t4.a",      1'b0, 2'b10, 2'b01, 2'b00, 2'b10);
        cyc("t4.b",      1'b0, 2'b10, 2'b01, 2'b00, 2'b10);
        cyc("t4.c",      1'b0, 2'b10, 2'b01, 2'b00, 2'b10);
        cyc("t4.d",      1'b0, 2'b10, 2'b01, 2'b00, 2'b10);
        cyc("t4.e",      1'b0, 2'b00, 2'b01, 2'b10, 2'b00);
        cyc("t4.force",  1'b0, 2'b11, 2'b01, 2'b00, 2'b01);
        cyc("t4.own",    1'b0, 2'b11, 2'b00, 2'b00, 2'b01);
        cyc("t4.done",   1'b0, 2'b00, 2'b00, 2'b01, 2'b00);
        // counter cleared by the grant: fixed priority applies again
        cyc("t4.clr",    1'b0, 2'b11, 2'b00, 2'b00, 2'b10);
        cyc("t4.clrdn",  1'b0, 2'b00, 2'b00, 2'b10, 2'b00);

        // reset mid-transaction with IFU counter saturated; counters must be cleared too
        cyc("t6.req",    1'b0, 2'b11, 2'b00, 2'b00, 2'b10);
        cyc("t6.own",    1'b0, 2'b11, 2'b00, 2'b00, 2'b10);
        cyc("t6.own2",   1'b0, 2'b11, 2'b00, 2'b00, 2'b10);
        cyc("t6.rst",    1'b1, 2'b11, 2'b00, 2'b00, 2'b00);
        cyc("t6.postrq", 1'b0, 2'b11, 2'b00, 2'b10, 2'b10);
        cyc("t6.postdn", 1'b0, 2'b00, 2'b00, 2'b10, 2'b00);
        cyc("t6.quiet",  1'b0, 2'b00, 2'b00, 2'b10, 2'b00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
